// File: rtl/tap_ctrl_regs.sv
// tap_ctrl_regs: IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and USER data registers
module tap_ctrl_regs #(
    parameter int                  IR_WIDTH     = 4,
    parameter int                  DR_WIDTH     = 8,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(2)
) (
    input  logic                clk,
    input  logic                TRST_n,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                tdo_en,
    output logic [3:0]          state_obs,
    output logic [IR_WIDTH-1:0] instr,
    input  logic [DR_WIDTH-1:0] user_in,
    output logic [DR_WIDTH-1:0] user_out,
    output logic                user_update
);
    typedef enum logic [3:0] {
        TLR       = 4'd0,
        RTI       = 4'd1,
        SEL_DR    = 4'd2,
        CAP_DR    = 4'd3,
        SHIFT_DR  = 4'd4,
        EXIT1_DR  = 4'd5,
        PAUSE_DR  = 4'd6,
        EXIT2_DR  = 4'd7,
        UPDATE_DR = 4'd8,
        SEL_IR    = 4'd9,
        CAP_IR    = 4'd10,
        SHIFT_IR  = 4'd11,
        EXIT1_IR  = 4'd12,
        PAUSE_IR  = 4'd13,
        EXIT2_IR  = 4'd14,
        UPDATE_IR = 4'd15
    } state_t;

    state_t state, state_nxt;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0] id_shift;
    logic [DR_WIDTH-1:0] user_shift;
    logic bypass_reg, sel_idcode, sel_user, dr_tdo, user_wr;

    assign sel_idcode = instr == INSTR_IDCODE;
    assign sel_user   = instr == INSTR_USER;
    assign user_wr    = state == UPDATE_DR && sel_user;

    // TAP state register
    always_ff @(posedge clk)
        state <= !TRST_n ? TLR : state_nxt;

    // TAP next-state decode driven by TMS
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:                       state_nxt = TMS ? TLR : RTI;
            RTI, UPDATE_DR, UPDATE_IR: state_nxt = TMS ? SEL_DR : RTI;
            SEL_DR:                    state_nxt = TMS ? SEL_IR : CAP_DR;
            SEL_IR:                    state_nxt = TMS ? TLR : CAP_IR;
            CAP_DR, SHIFT_DR:          state_nxt = TMS ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:                  state_nxt = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:                  state_nxt = TMS ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:                  state_nxt = TMS ? UPDATE_DR : SHIFT_DR;
            CAP_IR, SHIFT_IR:          state_nxt = TMS ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:                  state_nxt = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:                  state_nxt = TMS ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:                  state_nxt = TMS ? UPDATE_IR : SHIFT_IR;
            default:                   state_nxt = TLR;
        endcase
    end

    // Instruction shift register and active instruction
    always_ff @(posedge clk) begin
        if (!TRST_n) begin
            ir_shift <= '0;
            instr    <= INSTR_IDCODE;
        end else begin
            case (state)
                TLR:       instr    <= INSTR_IDCODE;
                CAP_IR:    ir_shift <= IR_WIDTH'(2'b01);
                SHIFT_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR: instr    <= ir_shift;
                default:   ;
            endcase
        end
    end

    // Capture and shift of whichever data register the instruction selects
    always_ff @(posedge clk) begin
        if (!TRST_n) begin
            bypass_reg <= 1'b0;
            id_shift   <= '0;
            user_shift <= '0;
        end else if (state == CAP_DR) begin
            if (sel_idcode)
                id_shift <= IDCODE_VAL;
            else if (sel_user)
                user_shift <= user_in;
            else
                bypass_reg <= 1'b0;
        end else if (state == SHIFT_DR) begin
            if (sel_idcode)
                id_shift <= {TDI, id_shift[31:1]};
            else if (sel_user)
                user_shift <= DR_WIDTH'({TDI, user_shift} >> 1);
            else
                bypass_reg <= TDI;
        end
    end

    // USER parallel output and its one-cycle write strobe
    always_ff @(posedge clk) begin
        if (!TRST_n) begin
            user_out    <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= user_wr;
            if (user_wr)
                user_out <= user_shift;
        end
    end

    assign dr_tdo    = sel_idcode ? id_shift[0] : sel_user ? user_shift[0] : bypass_reg;
    assign TDO       = state == SHIFT_IR ? ir_shift[0] : state == SHIFT_DR ? dr_tdo : 1'b0;
    assign tdo_en    = state == SHIFT_IR || state == SHIFT_DR;
    assign state_obs = state;
endmodule

// File: tb/tb_tap_ctrl_regs.sv
// tb_tap_ctrl_regs: directed and random checks of tap_ctrl_regs against a queue-based TAP model
module tb_tap_ctrl_regs;
    localparam int IW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic TRST_n = 1'b1, TMS = 1'b0, TDI = 1'b0;
    logic TDO, tdo_en, user_update;
    logic [3:0] state_obs;
    logic [IW-1:0] instr;
    logic [DW-1:0] user_in = '0;
    logic [DW-1:0] user_out;

    int n_cmp = 0, n_err = 0, upd_seen = 0;
    logic last_tdo;
    bit m_valid = 0;
    int m_st;
    logic [IW-1:0] m_instr;
    logic [DW-1:0] m_uout;
    logic m_upd;
    bit q_ir[$];
    bit q_dr[$];
    int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    always #5 clk = ~clk;

    tap_ctrl_regs dut (
        .clk(clk), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
        .state_obs(state_obs), .instr(instr), .user_in(user_in), .user_out(user_out),
        .user_update(user_update)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qval(input bit q[$]);
        logic [31:0] r = '0;
        for (int i = 0; i < q.size() && i < 32; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic model_edge(input logic tms_i, input logic tdi_i, input logic rst_i);
        bit su;
        int n;
        logic [31:0] v;
        if (!rst_i) begin
            m_st = 0; m_instr = IW'(1); m_uout = '0; m_upd = 1'b0;
            q_ir = {}; q_dr = {}; m_valid = 1;
            return;
        end
        su = m_instr == IW'(2);
        m_upd = m_st == 8 && su;
        if (m_st == 0) m_instr = IW'(1);
        if (m_st == 10) begin
            q_ir = {};
            for (int i = 0; i < IW; i++) q_ir.push_back(i == 0);
        end
        if (m_st == 11) begin
            void'(q_ir.pop_front());
            q_ir.push_back(tdi_i);
        end
        if (m_st == 15) begin
            v = qval(q_ir);
            m_instr = v[IW-1:0];
        end
        if (m_st == 3) begin
            n = su ? DW : (m_instr == IW'(1)) ? 32 : 1;
            v = su ? 32'(user_in) : (m_instr == IW'(1)) ? 32'h1000_0001 : 32'h0;
            q_dr = {};
            for (int i = 0; i < n; i++) q_dr.push_back(v[i]);
        end
        if (m_st == 4) begin
            void'(q_dr.pop_front());
            q_dr.push_back(tdi_i);
        end
        if (m_st == 8 && su) begin
            v = qval(q_dr);
            m_uout = v[DW-1:0];
        end
        m_st = tms_i ? nx1[m_st] : nx0[m_st];
    endtask

    task automatic step(input logic tms_i, input logic tdi_i, input logic rst_i = 1'b1);
        TMS = tms_i; TDI = tdi_i; TRST_n = rst_i;
        #1;
        if (m_valid) begin
            chk("state_obs", 32'(state_obs), 32'(m_st));
            chk("instr", 32'(instr), 32'(m_instr));
            chk("user_out", 32'(user_out), 32'(m_uout));
            chk("user_update", 32'(user_update), 32'(m_upd));
            chk("tdo_en", 32'(tdo_en), 32'(m_st == 4 || m_st == 11));
            chk("tdo", 32'(TDO), 32'(m_st == 11 ? q_ir[0] : m_st == 4 ? q_dr[0] : 1'b0));
            upd_seen += int'(user_update);
        end
        last_tdo = TDO;
        @(posedge clk);
        model_edge(tms_i, tdi_i, rst_i);
        @(negedge clk);
    endtask

    task automatic load_ir(input logic [IW-1:0] op, output logic [IW-1:0] cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IW; i++) begin
            step(i == IW - 1, op[i]);
            cap[i] = last_tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i]);
            dout[i] = last_tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    initial begin
        logic [IW-1:0] cap;
        logic [31:0] d;
        int cnt;
        step(0, 0, 0);
        chk("t1_rst_state", 32'(state_obs), 32'd0);
        chk("t1_rst_instr", 32'(instr), 32'd1);
        chk("t1_rst_user_out", 32'(user_out), 32'd0);
        chk("t1_rst_update", 32'(user_update), 32'd0);
        step(0, 0);
        chk("t1_rti", 32'(state_obs), 32'd1);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 32; i++) begin
            step(i == 31, 0);
            d[i] = last_tdo;
        end
        chk("t2_idcode", d, 32'h1000_0001);
        chk("t2_exit1", 32'(state_obs), 32'd5);
        step(1, 0); step(0, 0);
        load_ir(4'b1111, cap);
        chk("t3_ir_capture", 32'(cap), 32'b0001);
        chk("t3_instr", 32'(instr), 32'hF);
        dr_scan(3, 32'b101, d);
        chk("t3_bypass", d, 32'b010);
        user_in = 8'hA5;
        load_ir(4'b0010, cap);
        chk("t4_instr", 32'(instr), 32'h2);
        cnt = upd_seen;
        dr_scan(8, 32'h3C, d);
        chk("t4_tdo", d, 32'hA5);
        chk("t4_user_out", 32'(user_out), 32'h3C);
        chk("t4_upd_hi", 32'(user_update), 32'd1);
        step(0, 0);
        chk("t4_upd_lo", 32'(user_update), 32'd0);
        chk("t4_upd_count", 32'(upd_seen - cnt), 32'd1);
        load_ir(4'b0111, cap);
        cnt = upd_seen;
        dr_scan(3, 32'b101, d);
        step(0, 0);
        chk("t5_bypass", d, 32'b010);
        chk("t5_no_update", 32'(upd_seen - cnt), 32'd0);
        chk("t5_user_out_kept", 32'(user_out), 32'h3C);
        step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
        step(0, 1, 0);
        chk("t6_rst_state", 32'(state_obs), 32'd0);
        chk("t6_rst_instr", 32'(instr), 32'd1);
        chk("t6_rst_user_out", 32'(user_out), 32'd0);
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
        chk("t6_pause_ir", 32'(state_obs), 32'd13);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("t6_five_tms", 32'(state_obs), 32'd0);
        for (int i = 0; i < 4000; i++) begin
            user_in = DW'($urandom);
            step($urandom_range(0, 9) < 4, 1'($urandom), $urandom_range(0, 99) != 0);
        end
        step(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tap_ctrl_regs.md
Name: tap_ctrl_regs

Overview:
- Second-generation JTAG TAP controller.
- Contains the IEEE 1149.1 16-state TAP FSM plus a parametrised instruction register and three data registers: BYPASS, IDCODE, and a USER register with parallel in/out.
- Sits between the external test pins and on-chip debug/config logic.
- Exposes the current FSM state for observation and the decoded instruction for downstream consumers.

Parameters:
- IR_WIDTH, 4: instruction register width (>=2).
- DR_WIDTH, 8: USER data register width (>=1).
- IDCODE_VAL, 32'h1000_0001: value captured into the 32-bit IDCODE register; bit 0 must be 1.
- INSTR_IDCODE, 4'b0001: opcode selecting IDCODE; also the reset instruction.
- INSTR_USER, 4'b0010: opcode selecting the USER register.
- INSTR_BYPASS (fixed, all ones): opcode selecting BYPASS; any undefined opcode also selects BYPASS.

Ports:
- clk  in  1  TCK; all state changes on the rising edge.
- TRST_n  in  1  synchronous active-low reset.
- TMS  in  1  test mode select, sampled on rising clk.
- TDI  in  1  serial data in, sampled on rising clk.
- TDO  out  1  serial data out (combinational from current state and shift registers).
- tdo_en  out  1  high only while in Shift_IR or Shift_DR.
- state_obs  out  4  current FSM state encoding.
- instr  out  IR_WIDTH  active (updated) instruction.
- user_in  in  DR_WIDTH  parallel value captured into USER in Capture_DR.
- user_out  out  DR_WIDTH  USER value latched at Update_DR.
- user_update  out  1  one-cycle pulse when user_out is written.

Behaviour:

State encoding:
- Test_Logic_Reset=0, Run_Test_Idle=1, Select_DR=2, Capture_DR=3, Shift_DR=4, Exit1_DR=5, Pause_DR=6, Exit2_DR=7, Update_DR=8.
- Select_IR=9, Capture_IR=10, Shift_IR=11, Exit1_IR=12, Pause_IR=13, Exit2_IR=14, Update_IR=15.

FSM transitions, given as (TMS=0 / TMS=1):
- TLR: RTI / TLR.
- RTI: RTI / SelDR.
- SelDR: CapDR / SelIR.
- SelIR: CapIR / TLR.
- Capture_x: Shift_x / Exit1_x.
- Shift_x: Shift_x / Exit1_x.
- Exit1_x: Pause_x / Update_x.
- Pause_x: Pause_x / Exit2_x.
- Exit2_x: Shift_x / Update_x.
- Update_x: RTI / SelDR.
- Five consecutive TMS=1 edges reach TLR from any state.

Reset (TRST_n low at a rising edge):
- state=TLR, instr=INSTR_IDCODE.
- IR shift register=0, BYPASS=0, DR shift register=0, user_out=0, user_update=0.
- Reset overrides every other action in the same cycle, including mid-shift.

Register actions:
- Each action occurs at the rising edge where the current state is the named state. The next-state update happens on the same edge.
- TLR: instr <= INSTR_IDCODE every cycle spent in TLR.
- Capture_IR: IR shift <= {0...0,2'b01}.
- Shift_IR: IR shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
- Update_IR: instr <= IR shift.
- Capture_DR, by selected register:
  - BYPASS <= 0.
  - IDCODE shift <= IDCODE_VAL.
  - USER shift <= user_in.
- Shift_DR: the selected register shifts right, TDI enters at the MSB. BYPASS is a single bit (<= TDI).
- Update_DR with USER selected: user_out <= USER shift and user_update=1 for exactly the next cycle. user_update is 0 otherwise. BYPASS and IDCODE have no update action.
- The selected DR is fixed by instr. Because instr changes only in Update_IR or TLR, the selection never changes mid-DR-scan.

TDO and tdo_en:
- Shift_IR: TDO = ir_shift[0].
- Shift_DR: TDO = LSB of the selected DR.
- All other states: TDO = 0 and tdo_en = 0.

Other rules:
- Pause and Exit states hold all shift contents.
- The state_obs output is the state register with no extra delay.

Test Plan:
1. TRST_n=0 for 1 clk, then TMS=0 -> state_obs=0 then 1; instr=INSTR_IDCODE; user_out=0.
2. From RTI, TMS 1,0,0 then 32 Shift_DR edges (TMS=1 on the last) -> TDO sequence LSB-first equals 32'h1000_0001; state_obs=5 after the last.
3. IR scan: TMS 1,1,0,0 with TDI shifting 4'b1111 (last with TMS=1), then TMS 1 -> Update_IR. First two TDO bits are 1,0 (capture 01). instr=4'b1111 after Update_IR. A following DR scan shows a 1-cycle BYPASS delay: TDI pattern 1,0,1 appears on TDO shifted by one edge, first bit 0.
4. Load INSTR_USER with user_in=8'hA5, DR-scan shifting TDI=8'h3C -> TDO emits A5 LSB-first; after Update_DR, user_out=8'h3C and user_update high for exactly 1 clk.
5. Undefined opcode 4'b0111 loaded -> behaves as BYPASS; user_update never asserts.
6. Mid Shift_DR, TRST_n=0 for one edge -> state_obs=0, instr=INSTR_IDCODE, user_out unchanged from reset value 0 (no update). Separately, TMS=1 for 5 edges from Pause_IR -> state_obs=0.
